// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM states, master IDs
// and the default bus width.
package mem_bus_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    localparam logic ARB_M_IFU = 1'b0;
    localparam logic ARB_M_LSU = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to the
// master that did not win last time. Output is one-hot (or zero when idle).
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = 2'b00;
            grant[~last_grant] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises IFU (m0) and LSU (m1) transactions onto the single memory bus, one
// outstanding request at a time. Request fields are captured at grant.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW = CPU_WIDTH,
    parameter int DW = CPU_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_m0_req_valid,
    output logic            o_m0_req_ready,
    input  logic [AW-1:0]   i_m0_addr,
    output logic            o_m0_rsp_valid,
    input  logic            i_m0_rsp_ready,
    input  logic            i_m1_req_valid,
    output logic            o_m1_req_ready,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic            i_m1_wen,
    input  logic [DW-1:0]   i_m1_wdata,
    input  logic [DW/8-1:0] i_m1_wmask,
    output logic            o_m1_rsp_valid,
    input  logic            i_m1_rsp_ready,
    output logic [DW-1:0]   o_m_rdata,
    output logic            o_s_req_valid,
    input  logic            i_s_req_ready,
    output logic [AW-1:0]   o_s_addr,
    output logic            o_s_wen,
    output logic [DW-1:0]   o_s_wdata,
    output logic [DW/8-1:0] o_s_wmask,
    input  logic            i_s_rsp_valid,
    output logic            o_s_rsp_ready,
    input  logic [DW-1:0]   i_s_rdata
);

    localparam int MW = DW / 8;

    arb_state_t      state_q, state_d;
    logic            owner_q;
    logic            last_grant_q;
    logic [AW-1:0]   addr_q;
    logic            wen_q;
    logic [DW-1:0]   wdata_q;
    logic [MW-1:0]   wmask_q;

    logic [1:0]      grant;
    logic            grant_fire;
    logic            rsp_fire;
    logic            owner_rsp_ready;
    logic            lsu_wins;

    rr_arbiter2 u_rr (
        .valid      ({i_m1_req_valid, i_m0_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign lsu_wins        = grant[ARB_M_LSU];
    assign owner_rsp_ready = (owner_q == ARB_M_LSU) ? i_m1_rsp_ready : i_m0_rsp_ready;

    // Reset is synchronous, so the registers still hold stale values during the
    // reset cycle; gating keeps every output at 0 until reset has released.
    assign o_s_addr  = rst ? '0 : addr_q;
    assign o_s_wen   = rst ? 1'b0 : wen_q;
    assign o_s_wdata = rst ? '0 : wdata_q;
    assign o_s_wmask = rst ? '0 : wmask_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through here infers a latch.
        state_d        = state_q;
        grant_fire     = 1'b0;
        rsp_fire       = 1'b0;
        o_m0_req_ready = 1'b0;
        o_m1_req_ready = 1'b0;
        o_m0_rsp_valid = 1'b0;
        o_m1_rsp_valid = 1'b0;
        o_m_rdata      = '0;
        o_s_req_valid  = 1'b0;
        o_s_rsp_ready  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB_IDLE: begin
                    o_m0_req_ready = grant[ARB_M_IFU];
                    o_m1_req_ready = grant[ARB_M_LSU];
                    if (|grant) begin
                        grant_fire = 1'b1;
                        state_d    = ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    o_s_req_valid = 1'b1;
                    if (i_s_req_ready) state_d = ARB_RSP;
                end
                ARB_RSP: begin
                    o_s_rsp_ready = owner_rsp_ready;
                    o_m_rdata     = i_s_rdata;
                    if (owner_q == ARB_M_LSU) o_m1_rsp_valid = i_s_rsp_valid;
                    else                      o_m0_rsp_valid = i_s_rsp_valid;
                    if (i_s_rsp_valid && owner_rsp_ready) begin
                        rsp_fire = 1'b1;
                        state_d  = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= ARB_M_IFU;
            last_grant_q <= ARB_M_LSU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            if (grant_fire) begin
                // The IFU is read-only, so its write fields are forced to 0.
                owner_q <= lsu_wins;
                addr_q  <= lsu_wins ? i_m1_addr : i_m0_addr;
                wen_q   <= lsu_wins & i_m1_wen;
                wdata_q <= lsu_wins ? i_m1_wdata : '0;
                wmask_q <= lsu_wins ? i_m1_wmask : '0;
            end
            if (rsp_fire) last_grant_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_addr;
    logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready, m1_wen;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wmask;
    logic [31:0] m_rdata;
    logic        s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_m0_req_valid (m0_req_valid),
        .o_m0_req_ready (m0_req_ready),
        .i_m0_addr      (m0_addr),
        .o_m0_rsp_valid (m0_rsp_valid),
        .i_m0_rsp_ready (m0_rsp_ready),
        .i_m1_req_valid (m1_req_valid),
        .o_m1_req_ready (m1_req_ready),
        .i_m1_addr      (m1_addr),
        .i_m1_wen       (m1_wen),
        .i_m1_wdata     (m1_wdata),
        .i_m1_wmask     (m1_wmask),
        .o_m1_rsp_valid (m1_rsp_valid),
        .i_m1_rsp_ready (m1_rsp_ready),
        .o_m_rdata      (m_rdata),
        .o_s_req_valid  (s_req_valid),
        .i_s_req_ready  (s_req_ready),
        .o_s_addr       (s_addr),
        .o_s_wen        (s_wen),
        .o_s_wdata      (s_wdata),
        .o_s_wmask      (s_wmask),
        .i_s_rsp_valid  (s_rsp_valid),
        .o_s_rsp_ready  (s_rsp_ready),
        .i_s_rdata      (s_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one pending transaction record plus "has the slave
    // taken it yet", and who won last.
    bit          m_busy = 0, m_issued = 0, m_owner = 0, m_last = 1, m_fresh = 1;
    logic [31:0] m_addr = 0, m_wdata = 0;
    bit          m_wen = 0;
    logic [3:0]  m_wmask = 0;

    function automatic bit winner(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_issued = 0; m_owner = 0; m_last = 1; m_fresh = 1;
            m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0;
        end else if (!m_busy) begin
            if (m0_req_valid || m1_req_valid) begin
                m_owner  = winner(m0_req_valid, m1_req_valid, m_last);
                m_busy   = 1;
                m_issued = 0;
                m_fresh  = 0;
                m_addr   = m_owner ? m1_addr : m0_addr;
                m_wen    = m_owner ? m1_wen : 1'b0;
                m_wdata  = m_owner ? m1_wdata : 32'h0;
                m_wmask  = m_owner ? m1_wmask : 4'h0;
            end
        end else if (!m_issued) begin
            if (s_req_ready) m_issued = 1;
        end else if (s_rsp_valid && (m_owner ? m1_rsp_ready : m0_rsp_ready)) begin
            m_busy = 0;
            m_last = m_owner;
        end
    end

    bit          e_m0_rr, e_m1_rr, e_srv, e_srr, e_m0rv, e_m1rv, chk_fields, w;
    logic [31:0] e_rdata;

    always @(negedge clk) begin
        e_m0_rr = 0; e_m1_rr = 0; e_srv = 0; e_srr = 0; e_m0rv = 0; e_m1rv = 0;
        e_rdata = 0; chk_fields = 1;
        if (!rst) begin
            if (!m_busy) begin
                if (m0_req_valid || m1_req_valid) begin
                    w = winner(m0_req_valid, m1_req_valid, m_last);
                    if (w) e_m1_rr = 1; else e_m0_rr = 1;
                end
                chk_fields = m_fresh;
            end else if (!m_issued) begin
                e_srv = 1;
            end else begin
                chk_fields = 0;
                e_srr   = m_owner ? m1_rsp_ready : m0_rsp_ready;
                e_rdata = s_rdata;
                if (m_owner) e_m1rv = s_rsp_valid; else e_m0rv = s_rsp_valid;
            end
        end
        check("m0_req_ready", m0_req_ready, e_m0_rr);
        check("m1_req_ready", m1_req_ready, e_m1_rr);
        check("s_req_valid",  s_req_valid,  e_srv);
        check("s_rsp_ready",  s_rsp_ready,  e_srr);
        check("m0_rsp_valid", m0_rsp_valid, e_m0rv);
        check("m1_rsp_valid", m1_rsp_valid, e_m1rv);
        check("m_rdata",      m_rdata,      e_rdata);
        if (chk_fields) begin
            check("s_addr",  s_addr,  rst ? 32'h0 : m_addr);
            check("s_wen",   s_wen,   rst ? 1'b0  : m_wen);
            check("s_wdata", s_wdata, rst ? 32'h0 : m_wdata);
            check("s_wmask", s_wmask, rst ? 4'h0  : m_wmask);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    int gq[$];

    initial begin
        rst = 1;
        m0_req_valid = 0; m0_addr = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wmask = 0; m1_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rdata = 0;

        // Reset: a request during reset is not accepted
        tick(); m0_req_valid = 1; m0_addr = 32'h8000_0000;
        #3 check("rst_m0_req_ready", m0_req_ready, 1'b0);
        check("rst_s_addr", s_addr, 32'h0);

        // Scenario 1: m0 fetch, slave immediate
        tick(); rst = 0; s_req_ready = 1; m0_rsp_ready = 1;
        #3 check("s1_T_m0_req_ready", m0_req_ready, 1'b1);
        check("s1_T_m1_req_ready", m1_req_ready, 1'b0);
        tick(); m0_req_valid = 0;
        #3 check("s1_T1_s_req_valid", s_req_valid, 1'b1);
        check("s1_T1_s_addr", s_addr, 32'h8000_0000);
        check("s1_T1_s_wen", s_wen, 1'b0);
        tick(); s_rsp_valid = 1; s_rdata = 32'h0000_0413;
        #3 check("s1_T2_m0_rsp_valid", m0_rsp_valid, 1'b1);
        check("s1_T2_rdata", m_rdata, 32'h0000_0413);
        tick(); s_rsp_valid = 0; m0_req_valid = 1; m0_addr = 32'h8000_0004;
        #3 check("s1_T3_idle_m0_req_ready", m0_req_ready, 1'b1);
        check("s1_T3_m0_rsp_valid", m0_rsp_valid, 1'b0);
        tick(); m0_req_valid = 0;
        tick(); s_rsp_valid = 1; s_rdata = 32'h0000_0013;
        tick(); s_rsp_valid = 0;

        // Scenario 2: m1 write
        m1_req_valid = 1; m1_addr = 32'h8000_1000; m1_wen = 1;
        m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF; m1_rsp_ready = 1;
        #3 check("s2_m1_req_ready", m1_req_ready, 1'b1);
        tick(); m1_req_valid = 0;
        #3 check("s2_s_wen", s_wen, 1'b1);
        check("s2_s_addr", s_addr, 32'h8000_1000);
        check("s2_s_wdata", s_wdata, 32'hDEAD_BEEF);
        check("s2_s_wmask", s_wmask, 4'hF);
        tick(); s_rsp_valid = 1;
        #3 check("s2_m1_rsp_valid", m1_rsp_valid, 1'b1);
        check("s2_m0_rsp_valid", m0_rsp_valid, 1'b0);
        tick(); s_rsp_valid = 0;
        #3 check("s2_m1_rsp_pulse_end", m1_rsp_valid, 1'b0);

        // Scenario 3: both valid every cycle from reset
        tick(); rst = 1;
        tick(); rst = 0; m0_req_valid = 1; m1_req_valid = 1; m1_wen = 0;
        m0_addr = 32'h8000_0010; m1_addr = 32'h8000_0020;
        s_req_ready = 1; s_rsp_valid = 1; s_rdata = 32'h11;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            #3;
            if (m0_req_ready) gq.push_back(0);
            if (m1_req_ready) gq.push_back(1);
        end
        tick(); m0_req_valid = 0; m1_req_valid = 0; s_rsp_valid = 0;
        check("s3_grant_count", gq.size(), 4);
        if (gq.size() == 4) begin
            check("s3_grant0", gq[0], 0);
            check("s3_grant1", gq[1], 1);
            check("s3_grant2", gq[2], 0);
            check("s3_grant3", gq[3], 1);
        end

        // Scenario 4: slave stalls request, m1 stalls response
        tick(); m1_req_valid = 1; m1_addr = 32'h8000_2000; m1_wen = 0;
        m1_wdata = 0; m1_wmask = 0; s_req_ready = 0; m1_rsp_ready = 0;
        #3 check("s4_m1_req_ready", m1_req_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(); m1_req_valid = 0; m1_addr = 32'h1234_5678;
            m0_req_valid = 1; m0_addr = 32'h8000_0100;
            #3 check("s4_stall_s_req_valid", s_req_valid, 1'b1);
            check("s4_stall_s_addr", s_addr, 32'h8000_2000);
            check("s4_stall_m0_req_ready", m0_req_ready, 1'b0);
        end
        tick(); s_req_ready = 1;
        #3 check("s4_s_req_valid", s_req_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'hCAFE_0001;
            #3 check("s4_hold_m1_rsp_valid", m1_rsp_valid, 1'b1);
            check("s4_hold_s_rsp_ready", s_rsp_ready, 1'b0);
            check("s4_hold_rdata", m_rdata, 32'hCAFE_0001);
        end
        tick(); m1_rsp_ready = 1;
        #3 check("s4_s_rsp_ready", s_rsp_ready, 1'b1);
        tick(); s_rsp_valid = 0;
        #3 check("s4_next_m0_req_ready", m0_req_ready, 1'b1);
        tick(); m0_req_valid = 0; s_req_ready = 1; m0_rsp_ready = 1;
        tick(); s_rsp_valid = 1; s_rdata = 32'h22;
        tick(); s_rsp_valid = 0;

        // Scenario 5: reset while in RSP
        m1_req_valid = 1; m1_addr = 32'h8000_3000; m1_rsp_ready = 0;
        #3 check("s5_m1_req_ready", m1_req_ready, 1'b1);
        tick(); m1_req_valid = 0;
        tick();
        tick(); rst = 1;
        #3 check("s5_rst_s_req_valid", s_req_valid, 1'b0);
        check("s5_rst_s_addr", s_addr, 32'h0);
        tick(); rst = 0; m0_req_valid = 1; m1_req_valid = 1;
        m0_addr = 32'h8000_0200; m1_addr = 32'h8000_0300;
        #3 check("s5_tie_m0_req_ready", m0_req_ready, 1'b1);
        check("s5_tie_m1_req_ready", m1_req_ready, 1'b0);
        tick(); m0_req_valid = 0; m1_req_valid = 0; s_req_ready = 1;
        #3 check("s5_s_addr", s_addr, 32'h8000_0200);
        tick(); s_rsp_valid = 1; m0_rsp_ready = 1;
        tick(); s_rsp_valid = 0;

        // Scenario 6: spurious response in IDLE
        for (int i = 0; i < 3; i++) begin
            tick(); s_rsp_valid = 1; s_rdata = 32'hFFFF_FFFF; m1_rsp_ready = 1;
            #3 check("s6_s_rsp_ready", s_rsp_ready, 1'b0);
            check("s6_m0_rsp_valid", m0_rsp_valid, 1'b0);
            check("s6_m1_rsp_valid", m1_rsp_valid, 1'b0);
            check("s6_rdata", m_rdata, 32'h0);
        end
        tick(); s_rsp_valid = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
